// File: rtl/iter_divider_if.sv
`timescale 1ns/1ps
// iter_divider_if
//   Command/result bundle for the iterative divider.
//   master : drives the command side (in_*), observes the result side (out_*)
//   slave  : the divider itself
//   Signals:
//     in_enable          command strobe
//     in_unsgn_or_sgn    0 = unsigned, 1 = signed
//     in_num / in_denom  operands, ARGS_WIDTH bits
//     in_data_ack        consumer has taken the held result
//     out_can_accept_cmd a command presented now will be taken
//     out_data_ready     out_quot/out_rem/flags are valid
//     out_quot / out_rem result, ARGS_WIDTH bits
//     out_div_by_zero    result came from the zero-denominator path
//     out_overflow       result came from signed MIN / -1
interface iter_divider_if #(
  parameter int ARGS_WIDTH = 32
);
  logic                  in_enable;
  logic                  in_unsgn_or_sgn;
  logic [ARGS_WIDTH-1:0] in_num;
  logic [ARGS_WIDTH-1:0] in_denom;
  logic                  in_data_ack;
  logic                  out_can_accept_cmd;
  logic                  out_data_ready;
  logic [ARGS_WIDTH-1:0] out_quot;
  logic [ARGS_WIDTH-1:0] out_rem;
  logic                  out_div_by_zero;
  logic                  out_overflow;

  modport master (
    output in_enable, in_unsgn_or_sgn, in_num, in_denom, in_data_ack,
    input  out_can_accept_cmd, out_data_ready, out_quot, out_rem,
           out_div_by_zero, out_overflow
  );

  modport slave (
    input  in_enable, in_unsgn_or_sgn, in_num, in_denom, in_data_ack,
    output out_can_accept_cmd, out_data_ready, out_quot, out_rem,
           out_div_by_zero, out_overflow
  );
endinterface

// File: rtl/iter_divider.sv
`timescale 1ns/1ps
// iter_divider
//   Multi-cycle signed/unsigned integer divider (DIV/DIVU/REM/REMU).
//   Non-restoring algorithm resolving NUM_ITERATIONS_PER_CYCLE quotient bits
//   per cycle. Quotient truncates toward zero, remainder takes the sign of
//   the numerator. Divide-by-zero returns all-ones / raw numerator; signed
//   MIN / -1 returns MIN / 0. The result is held until acknowledged or
//   until a new command is accepted.
//   Ports:
//     clk  clock
//     rst  synchronous active-high reset
//     bus  iter_divider_if.slave (command and result signals)
//   Optional feature macro: ITER_DIVIDER_EARLY_OUT_EN
//     When defined, |num| < |denom| skips the iteration phase.
module iter_divider #(
  parameter int ARGS_WIDTH               = 32,
  parameter int NUM_ITERATIONS_PER_CYCLE = 1
) (
  input  logic          clk,
  input  logic          rst,
  iter_divider_if.slave bus
);

  localparam int W  = ARGS_WIDTH;
  localparam int K  = NUM_ITERATIONS_PER_CYCLE;
  localparam int PW = 2 * W + 1;           // partial remainder width
  localparam int CW = $clog2(W) + 1;       // bit-index counter width
  localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

  generate
    if (W < 8 || W > 128) begin : g_bad_width
      $error("iter_divider: ARGS_WIDTH must be in 8..128");
    end
    if (K < 1 || (W % K) != 0) begin : g_bad_iter
      $error("iter_divider: NUM_ITERATIONS_PER_CYCLE must divide ARGS_WIDTH");
    end
  endgenerate

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_ITER, S_FIXUP, S_DONE} state_t;
  typedef enum logic [1:0] {R_NORMAL, R_DIV_ZERO, R_OVERFLOW, R_EARLY} path_t;

  state_t                state_q, state_d;
  path_t                 path_q, path_d;
  logic                  sgn_q, sgn_d;
  logic                  num_neg_q, num_neg_d;
  logic                  den_neg_q, den_neg_d;
  logic [W-1:0]          num_raw_q, num_raw_d;
  logic [W-1:0]          num_mag_q, num_mag_d;
  logic [W-1:0]          den_mag_q, den_mag_d;
  logic signed [PW-1:0]  p_q, p_d;
  logic signed [PW-1:0]  d_q, d_d;
  logic [W-1:0]          q_q, q_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [W-1:0]          quot_q, quot_d;
  logic [W-1:0]          rem_q, rem_d;
  logic                  dz_q, dz_d;
  logic                  ov_q, ov_d;

  logic                  can_accept;
  logic                  accept;
  logic                  in_num_neg, in_den_neg;
  logic [W-1:0]          in_num_mag, in_den_mag;

  assign can_accept = (state_q == S_IDLE) || (state_q == S_DONE);
  assign accept     = bus.in_enable && can_accept;
  assign in_num_neg = bus.in_unsgn_or_sgn && bus.in_num[W-1];
  assign in_den_neg = bus.in_unsgn_or_sgn && bus.in_denom[W-1];
  assign in_num_mag = in_num_neg ? (-bus.in_num) : bus.in_num;
  assign in_den_mag = in_den_neg ? (-bus.in_denom) : bus.in_denom;

  // Chain of K non-restoring steps evaluated in one cycle. The sign of the
  // partial remainder entering each step selects subtract/add and gives the
  // quotient digit (1 when non-negative). Intermediate 2P may wrap, but the
  // step result always lies in [-D, D) so modular arithmetic is exact.
  logic signed [PW-1:0] p_stage [K+1];
  logic [K-1:0]         step_bits;
  logic [W-1:0]         q_next;

  assign p_stage[0] = p_q;

  generate
    for (genvar gi = 0; gi < K; gi++) begin : g_step
      assign step_bits[K-1-gi] = ~p_stage[gi][PW-1];
      assign p_stage[gi+1] = p_stage[gi][PW-1] ? ((p_stage[gi] <<< 1) + d_q)
                                               : ((p_stage[gi] <<< 1) - d_q);
    end
  endgenerate

  // Digits arrive MSB first, so shift them in at the bottom.
  assign q_next = W'({q_q, step_bits});

  // Convert the {+1,-1} digit set to binary, then correct a negative final
  // partial remainder by one restoring step.
  logic [W-1:0]         q_conv, q_fix, rem_mag, quot_signed, rem_signed;
  logic signed [PW-1:0] p_fix;

  always_comb begin
    q_conv      = q_q - ~q_q;
    q_fix       = p_q[PW-1] ? (q_conv - W'(1)) : q_conv;
    p_fix       = p_q[PW-1] ? (p_q + d_q) : p_q;
    rem_mag     = W'(p_fix >> W);
    quot_signed = (num_neg_q ^ den_neg_q) ? (-q_fix) : q_fix;
    rem_signed  = num_neg_q ? (-rem_mag) : rem_mag;
  end

  always_comb begin
    state_d   = state_q;
    path_d    = path_q;
    sgn_d     = sgn_q;
    num_neg_d = num_neg_q;
    den_neg_d = den_neg_q;
    num_raw_d = num_raw_q;
    num_mag_d = num_mag_q;
    den_mag_d = den_mag_q;
    p_d       = p_q;
    d_d       = d_q;
    q_d       = q_q;
    cnt_d     = cnt_q;
    quot_d    = quot_q;
    rem_d     = rem_q;
    dz_d      = dz_q;
    ov_d      = ov_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        // An accept in DONE implicitly consumes the held result.
        if (accept) begin
          state_d   = S_SETUP;
          sgn_d     = bus.in_unsgn_or_sgn;
          num_raw_d = bus.in_num;
          num_neg_d = in_num_neg;
          den_neg_d = in_den_neg;
          num_mag_d = in_num_mag;
          den_mag_d = in_den_mag;
        end else if (state_q == S_DONE && bus.in_data_ack) begin
          state_d = S_IDLE;
        end
      end

      S_SETUP: begin
        if (den_mag_q == '0) begin
          path_d  = R_DIV_ZERO;
          state_d = S_FIXUP;
        end else if (sgn_q && num_raw_q == MIN_VAL && den_neg_q &&
                     den_mag_q == W'(1)) begin
          path_d  = R_OVERFLOW;
          state_d = S_FIXUP;
        end
`ifdef ITER_DIVIDER_EARLY_OUT_EN
        else if (num_mag_q < den_mag_q) begin
          path_d  = R_EARLY;
          state_d = S_FIXUP;
        end
`endif
        else begin
          path_d  = R_NORMAL;
          p_d     = {{(W+1){1'b0}}, num_mag_q};
          d_d     = {1'b0, den_mag_q, {W{1'b0}}};
          q_d     = '0;
          cnt_d   = CW'(W - 1);
          state_d = S_ITER;
        end
      end

      S_ITER: begin
        p_d = p_stage[K];
        q_d = q_next;
        // cnt_q is the index of the highest digit resolved this cycle.
        if (cnt_q == CW'(K - 1)) begin
          state_d = S_FIXUP;
        end else begin
          cnt_d = cnt_q - CW'(K);
        end
      end

      S_FIXUP: begin
        state_d = S_DONE;
        case (path_q)
          R_DIV_ZERO: begin
            quot_d = '1;
            rem_d  = num_raw_q;
            dz_d   = 1'b1;
            ov_d   = 1'b0;
          end
          R_OVERFLOW: begin
            quot_d = MIN_VAL;
            rem_d  = '0;
            dz_d   = 1'b0;
            ov_d   = 1'b1;
          end
          R_EARLY: begin
            quot_d = '0;
            rem_d  = num_raw_q;
            dz_d   = 1'b0;
            ov_d   = 1'b0;
          end
          default: begin
            quot_d = quot_signed;
            rem_d  = rem_signed;
            dz_d   = 1'b0;
            ov_d   = 1'b0;
          end
        endcase
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      path_q    <= R_NORMAL;
      sgn_q     <= 1'b0;
      num_neg_q <= 1'b0;
      den_neg_q <= 1'b0;
      num_raw_q <= '0;
      num_mag_q <= '0;
      den_mag_q <= '0;
      p_q       <= '0;
      d_q       <= '0;
      q_q       <= '0;
      cnt_q     <= '0;
      quot_q    <= '0;
      rem_q     <= '0;
      dz_q      <= 1'b0;
      ov_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      path_q    <= path_d;
      sgn_q     <= sgn_d;
      num_neg_q <= num_neg_d;
      den_neg_q <= den_neg_d;
      num_raw_q <= num_raw_d;
      num_mag_q <= num_mag_d;
      den_mag_q <= den_mag_d;
      p_q       <= p_d;
      d_q       <= d_d;
      q_q       <= q_d;
      cnt_q     <= cnt_d;
      quot_q    <= quot_d;
      rem_q     <= rem_d;
      dz_q      <= dz_d;
      ov_q      <= ov_d;
    end
  end

  assign bus.out_can_accept_cmd = can_accept;
  assign bus.out_data_ready     = (state_q == S_DONE);
  assign bus.out_quot           = quot_q;
  assign bus.out_rem            = rem_q;
  assign bus.out_div_by_zero    = dz_q;
  assign bus.out_overflow       = ov_q;

endmodule

// File: tb/tb_iter_divider.sv
`timescale 1ns/1ps
// tb_iter_divider
//   Drives two divider instances (1 and 4 quotient bits per cycle, 32-bit
//   operands) through directed and random commands and compares each result,
//   flag and latency with a plain-arithmetic reference model.
module tb_iter_divider;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         en, sgn, ack, sel;
  logic [W-1:0] num, den;

  iter_divider_if #(.ARGS_WIDTH(W)) bus1 ();
  iter_divider_if #(.ARGS_WIDTH(W)) bus4 ();

  assign bus1.in_enable       = en && !sel;
  assign bus1.in_unsgn_or_sgn = sgn;
  assign bus1.in_num          = num;
  assign bus1.in_denom        = den;
  assign bus1.in_data_ack     = ack && !sel;
  assign bus4.in_enable       = en && sel;
  assign bus4.in_unsgn_or_sgn = sgn;
  assign bus4.in_num          = num;
  assign bus4.in_denom        = den;
  assign bus4.in_data_ack     = ack && sel;

  iter_divider #(.ARGS_WIDTH(W), .NUM_ITERATIONS_PER_CYCLE(1)) dut_k1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );
  iter_divider #(.ARGS_WIDTH(W), .NUM_ITERATIONS_PER_CYCLE(4)) dut_k4 (
    .clk(clk), .rst(rst), .bus(bus4)
  );

  wire         o_can   = sel ? bus4.out_can_accept_cmd : bus1.out_can_accept_cmd;
  wire         o_ready = sel ? bus4.out_data_ready     : bus1.out_data_ready;
  wire [W-1:0] o_quot  = sel ? bus4.out_quot           : bus1.out_quot;
  wire [W-1:0] o_rem   = sel ? bus4.out_rem            : bus1.out_rem;
  wire         o_dz    = sel ? bus4.out_div_by_zero    : bus1.out_div_by_zero;
  wire         o_ov    = sel ? bus4.out_overflow       : bus1.out_overflow;

  int           checks   = 0;
  int           failures = 0;
  logic [W-1:0] last_q, last_r;
  int           txn = 0;

  task automatic check_eq(input string tag, input logic [63:0] act,
                          input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  // Reference: division rules applied with native SV arithmetic.
  function automatic void ref_div(input bit s, input logic [W-1:0] a,
                                  input logic [W-1:0] b, input int k,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output bit dz, output bit ov, output int lat);
    int          sa, sb;
    logic [W-1:0] ma, mb;
    sa  = $signed(a);
    sb  = $signed(b);
    ma  = (s && a[W-1]) ? -a : a;
    mb  = (s && b[W-1]) ? -b : b;
    dz  = 1'b0;
    ov  = 1'b0;
    lat = (W / k) + 2;
    if (b == 0) begin
      q = '1; r = a; dz = 1'b1; lat = 2;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = '0; ov = 1'b1; lat = 2;
    end else begin
      if (s) begin
        q = 32'(sa / sb);
        r = 32'(sa % sb);
      end else begin
        q = a / b;
        r = a % b;
      end
`ifdef ITER_DIVIDER_EARLY_OUT_EN
      if (ma < mb) lat = 2;
`else
      if (ma < mb) lat = (W / k) + 2;
`endif
    end
  endfunction

  task automatic start_cmd(input bit s, input logic [W-1:0] a,
                           input logic [W-1:0] b, input bit with_ack);
    check_eq("can_accept_before_cmd", 64'(o_can), 64'd1);
    en = 1'b1; ack = with_ack; sgn = s; num = a; den = b;
    @(posedge clk); #1;
    en = 1'b0; ack = 1'b0;
  endtask

  // pre = edges already elapsed since the accept edge.
  task automatic wait_and_check(input bit s, input logic [W-1:0] a,
                                input logic [W-1:0] b, input int pre);
    logic [W-1:0] eq, er;
    bit           edz, eov;
    int           elat, lat;
    ref_div(s, a, b, sel ? 4 : 1, eq, er, edz, eov, elat);
    lat = pre;
    while (!o_ready && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    txn++;
    $display("txn %0d k=%0d sgn=%0d %h / %h -> q=%h r=%h dz=%0d ov=%0d lat=%0d",
             txn, sel ? 4 : 1, s, a, b, o_quot, o_rem, o_dz, o_ov, lat);
    check_eq("ready", 64'(o_ready), 64'd1);
    check_eq("latency", 64'(lat), 64'(elat));
    check_eq("quot", 64'(o_quot), 64'(eq));
    check_eq("rem", 64'(o_rem), 64'(er));
    check_eq("div_by_zero", 64'(o_dz), 64'(edz));
    check_eq("overflow", 64'(o_ov), 64'(eov));
    last_q = eq;
    last_r = er;
  endtask

  task automatic ack_result();
    ack = 1'b1;
    @(posedge clk); #1;
    ack = 1'b0;
    check_eq("ready_after_ack", 64'(o_ready), 64'd0);
    check_eq("can_accept_after_ack", 64'(o_can), 64'd1);
    check_eq("quot_kept_after_ack", 64'(o_quot), 64'(last_q));
    check_eq("rem_kept_after_ack", 64'(o_rem), 64'(last_r));
  endtask

  task automatic run_directed(input bit s, input logic [W-1:0] a,
                              input logic [W-1:0] b);
    start_cmd(s, a, b, 1'b0);
    wait_and_check(s, a, b, 0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("ready_held", 64'(o_ready), 64'd1);
    check_eq("quot_held", 64'(o_quot), 64'(last_q));
    check_eq("rem_held", 64'(o_rem), 64'(last_r));
    ack_result();
  endtask

  task automatic run_random(input int n);
    bit           pending = 1'b0;
    bit           s, bb;
    logic [W-1:0] a, b;
    for (int i = 0; i < n; i++) begin
      s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0: begin a = $urandom; b = $urandom; end
        1: begin a = $urandom_range(0, 50); b = $urandom_range(0, 12); end
        2: begin a = $urandom; b = '0; end
        3: begin
          a = 32'h8000_0000;
          b = $urandom_range(0, 1) ? 32'hFFFF_FFFF : 32'h0000_0001;
          s = 1'b1;
        end
        4: begin b = $urandom; a = b >> $urandom_range(1, 8); end
        default: begin a = $urandom; b = $urandom >> $urandom_range(0, 28); end
      endcase
      bb = 1'($urandom_range(0, 1));
      if (pending && !bb) ack_result();
      start_cmd(s, a, b, pending && bb);
      wait_and_check(s, a, b, 0);
      pending = 1'b1;
    end
    if (pending) ack_result();
  endtask

  logic [W-1:0] dir_a [8] = '{32'd100, -32'sd7, 32'd7, 32'hFFFF_FFF9,
                              32'd5, 32'd5, 32'h8000_0000, 32'd3};
  logic [W-1:0] dir_b [8] = '{32'd7, 32'd2, -32'sd2, 32'd2,
                              32'd0, 32'd0, 32'hFFFF_FFFF, 32'd10};
  bit           dir_s [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    rst = 1'b1; en = 1'b0; ack = 1'b0; sgn = 1'b0; num = '0; den = '0;
    sel = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      sel = 1'(d);
      #1;
      check_eq("rst_can_accept", 64'(o_can), 64'd1);
      check_eq("rst_ready", 64'(o_ready), 64'd0);
      check_eq("rst_quot", 64'(o_quot), 64'd0);
      check_eq("rst_rem", 64'(o_rem), 64'd0);
      check_eq("rst_dz", 64'(o_dz), 64'd0);
      check_eq("rst_ov", 64'(o_ov), 64'd0);
    end
    rst = 1'b0;
    sel = 1'b0;
    @(posedge clk); #1;

    // Directed cases, one bit per cycle.
    for (int i = 0; i < 8; i++) run_directed(dir_s[i], dir_a[i], dir_b[i]);

    // Leave non-zero outputs behind, then reset in the middle of ITER.
    run_directed(1'b0, 32'd5, 32'd0);
    start_cmd(1'b0, 32'd123456, 32'd7, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    check_eq("busy_before_reset", 64'(o_can), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("midrst_can_accept", 64'(o_can), 64'd1);
    check_eq("midrst_ready", 64'(o_ready), 64'd0);
    check_eq("midrst_quot", 64'(o_quot), 64'd0);
    check_eq("midrst_rem", 64'(o_rem), 64'd0);
    check_eq("midrst_dz", 64'(o_dz), 64'd0);
    check_eq("midrst_ov", 64'(o_ov), 64'd0);
    run_directed(1'b0, 32'd9, 32'd3);

    // Four bits per cycle: back-to-back accept+ack, then a busy pulse.
    sel = 1'b1;
    #1;
    start_cmd(1'b0, 32'd50, 32'd7, 1'b0);
    wait_and_check(1'b0, 32'd50, 32'd7, 0);
    start_cmd(1'b0, 32'd1000, 32'd10, 1'b1);
    wait_and_check(1'b0, 32'd1000, 32'd10, 0);
    start_cmd(1'b1, -32'sd12345, 32'd67, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    check_eq("busy_can_accept", 64'(o_can), 64'd0);
    en = 1'b1; ack = 1'b1; sgn = 1'b0; num = 32'd77; den = 32'd3;
    @(posedge clk); #1;
    en = 1'b0; ack = 1'b0;
    wait_and_check(1'b1, -32'sd12345, 32'd67, 3);
    ack_result();

    run_random(30);
    sel = 1'b0;
    #1;
    run_random(30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/iter_divider.md
Name: iter_divider

Overview:
- Parametrised multi-cycle integer divider that supersedes the fixed single-mode non-restoring divider.
- Supports configurable operand width and radix-2 iterations per cycle, plus signed and unsigned modes.
- Defines explicit divide-by-zero and signed-overflow results and holds each result until the consumer acknowledges it.
- Sits beside the ALU as the DIV/DIVU/REM/REMU execution resource.

Parameters:
- ARGS_WIDTH, 32, operand/result width; legal 8..128.
- NUM_ITERATIONS_PER_CYCLE, 1, quotient bits resolved per ITER cycle; must divide ARGS_WIDTH, otherwise an elaboration-time $error.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_enable  in  1  command strobe
- in_unsgn_or_sgn  in  1  0 = unsigned, 1 = signed
- in_num  in  ARGS_WIDTH  numerator
- in_denom  in  ARGS_WIDTH  denominator
- in_data_ack  in  1  consumer has taken the result
- out_can_accept_cmd  out  1  command will be accepted this cycle
- out_data_ready  out  1  out_quot/out_rem/flags valid
- out_quot  out  ARGS_WIDTH  quotient
- out_rem  out  ARGS_WIDTH  remainder
- out_div_by_zero  out  1  result came from the zero-denominator path
- out_overflow  out  1  result came from signed MIN / -1

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high on rst. All state updates on posedge clk.
- Reset values: state=IDLE, out_can_accept_cmd=1, out_data_ready=0, out_quot=0, out_rem=0, both flags=0.
- Reset mid-operation aborts the division; no result is produced.
- States: IDLE, SETUP, ITER, FIXUP, DONE.
- out_can_accept_cmd = (state==IDLE) || (state==DONE), combinational from state.
- Accept: in_enable && out_can_accept_cmd at a clock edge latches the mode, operands and sign bits. In signed mode both operands are converted to magnitudes. The state then moves to SETUP.
- In DONE, an accept also consumes the held result; this is the same as an ack. in_enable while busy (SETUP/ITER/FIXUP) is ignored with no side effects.
- SETUP:
  - Denominator == 0 -> FIXUP with div-zero flag set.
  - Signed, num == MIN and denom == -1 -> FIXUP with overflow flag set.
  - Otherwise: load P = magnitude(num) (2*W+1 bits, zero-extended), D = magnitude(denom) << W, counter = W-1, then go to ITER.
- ITER: each cycle performs NUM_ITERATIONS_PER_CYCLE non-restoring steps.
  - Each step: if P >= 0, q[counter]=1 and P = 2P - D; else q[counter]=0 and P = 2P + D; counter decrements.
  - After C = W/NUM_ITERATIONS_PER_CYCLE cycles, go to FIXUP.
- FIXUP, normal path:
  - Q = q - ~q; if P < 0 then Q -= 1 and P += D.
  - rem = P >> W.
  - Signed mode negates Q if the operand signs differ, and negates rem if num was negative.
  - Result truncates toward zero; remainder takes the numerator's sign.
- FIXUP, special paths:
  - Div-zero: quot = all ones, rem = in_num as latched (raw, not magnitude), out_div_by_zero=1. Same in signed and unsigned mode.
  - Overflow: quot = MIN, rem = 0, out_overflow=1.
- Outputs are registered in FIXUP and the state moves to DONE, where out_data_ready=1.
- Latency from the accept edge to out_data_ready high:
  - Normal path: C+2 edges (W=32: K=1 -> 34, K=2 -> 18, K=4 -> 10).
  - Special paths: 2 edges.
- DONE holds all outputs stable until in_data_ack or a new accept.
  - in_data_ack alone -> IDLE; out_data_ready drops next cycle while data outputs retain their values.
  - ack and accept in the same cycle -> SETUP with the new command.
- in_data_ack outside DONE is ignored.

Optional Feature:
- Macro: ITER_DIVIDER_EARLY_OUT_EN.
- Defined: in SETUP, if magnitude(num) < magnitude(denom) and the divisor is nonzero, skip ITER and go to FIXUP with quot = 0 and rem = in_num (raw). Latency 2 edges. The overflow case cannot take this path.
- Undefined: no comparator in SETUP; every nonzero-divisor, non-overflow command takes the full C+2 latency. Results are identical either way.

Test Plan:
- Unsigned, W=32, K=1: 100 / 7 -> quot=14, rem=2; out_data_ready exactly 34 edges after accept; holds until ack.
- Signed: -7 / 2 -> quot=0xFFFFFFFD, rem=0xFFFFFFFF. Signed: 7 / -2 -> quot=0xFFFFFFFD, rem=1. Unsigned: 0xFFFFFFF9 / 2 -> quot=0x7FFFFFFC, rem=1.
- Div-zero: 5 / 0, both modes -> quot=0xFFFFFFFF, rem=5, out_div_by_zero=1, latency 2. Signed overflow: 0x80000000 / 0xFFFFFFFF -> quot=0x80000000, rem=0, out_overflow=1.
- K=4 back-to-back: in DONE, raise in_enable and in_data_ack together with 1000 / 10 -> new result 100 r 0 after 10 edges, no idle gap; an in_enable pulse issued during ITER is ignored.
- Reset mid-op: assert rst at ITER cycle 5 -> next cycle IDLE, out_can_accept_cmd=1, out_data_ready=0, outputs 0; the following 9 / 3 -> 3 r 0.
- Early-out, macro on: 3 / 10 -> quot=0, rem=3 in 2 edges. Macro off: same result in 34 edges (K=1).
